// File: rtl/div_issue_ctrl.sv
// ============================================================================
//  Module   : div_issue_ctrl
//  Purpose  : Issue/retire controller for the iterative 64-bit divider core.
//             Optional last-result cache enabled by DIV_RESULT_CACHE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic        in_word,
    input  logic [63:0] in_src1,
    input  logic [63:0] in_src2,
    input  logic [4:0]  in_rd,
    output logic        div_valid,
    output logic [63:0] div_a,
    output logic [63:0] div_b,
    output logic        div_signed,
    output logic        div_flush,
    input  logic        div_result_valid,
    input  logic [63:0] div_quotient,
    input  logic [63:0] div_remainder,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic        busy
);

    localparam logic [1:0]  c_IDLE   = 2'd0;
    localparam logic [1:0]  c_ISSUE  = 2'd1;
    localparam logic [1:0]  c_WAIT   = 2'd2;
    localparam logic [1:0]  c_DONE   = 2'd3;
    localparam logic [63:0] c_MIN64  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_MIN32X = 64'hFFFF_FFFF_8000_0000;
    localparam logic [63:0] c_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] f_prep(input logic [63:0] src, input logic sgn, input logic word);
        if (!word)    return src;
        else if (sgn) return {{32{src[31]}}, src[31:0]};
        else          return {32'd0, src[31:0]};
    endfunction

    // Every W result is sign-extended from bit 31, unsigned variants included.
    function automatic logic [63:0] f_fmt(input logic [63:0] v, input logic word);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [63:0] r_a, r_b, r_out_data;
    logic        r_signed, r_rem, r_word;
    logic [4:0]  r_rd;

    logic        w_signed, w_div0, w_ovf, w_hit, w_fast, w_accept, w_capture;
    logic [63:0] w_a, w_b, w_spec_q, w_spec_r, w_hit_q, w_hit_r, w_fast_data, w_core_data;

    assign w_signed = ~in_op[0];
    assign w_a      = f_prep(in_src1, w_signed, in_word);
    assign w_b      = f_prep(in_src2, w_signed, in_word);
    assign w_div0   = (w_b == 64'd0);
    assign w_ovf    = w_signed & (w_b == c_ONES) & (w_a == (in_word ? c_MIN32X : c_MIN64));
    assign w_spec_q = w_div0 ? c_ONES : w_a;
    assign w_spec_r = w_div0 ? w_a    : 64'd0;

    assign w_accept  = in_valid & in_ready;
    assign w_capture = (r_state == c_WAIT) & div_result_valid & ~flush;

`ifdef DIV_RESULT_CACHE_EN
    logic        r_cache_valid, r_cache_signed, r_cache_word;
    logic [63:0] r_cache_a, r_cache_b, r_cache_q, r_cache_r;

    // Only completions that survive to capture are remembered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cache_valid  <= 1'b0;
            r_cache_signed <= 1'b0;
            r_cache_word   <= 1'b0;
            r_cache_a      <= 64'd0;
            r_cache_b      <= 64'd0;
            r_cache_q      <= 64'd0;
            r_cache_r      <= 64'd0;
        end else if (w_capture) begin
            r_cache_valid  <= 1'b1;
            r_cache_signed <= r_signed;
            r_cache_word   <= r_word;
            r_cache_a      <= r_a;
            r_cache_b      <= r_b;
            r_cache_q      <= div_quotient;
            r_cache_r      <= div_remainder;
        end
    end

    assign w_hit   = r_cache_valid & (r_cache_a == w_a) & (r_cache_b == w_b)
                   & (r_cache_signed == w_signed) & (r_cache_word == in_word);
    assign w_hit_q = r_cache_q;
    assign w_hit_r = r_cache_r;
`else
    assign w_hit   = 1'b0;
    assign w_hit_q = 64'd0;
    assign w_hit_r = 64'd0;
`endif

    assign w_fast      = w_div0 | w_ovf | w_hit;
    assign w_fast_data = f_fmt(in_op[1] ? ((w_div0 | w_ovf) ? w_spec_r : w_hit_r)
                                        : ((w_div0 | w_ovf) ? w_spec_q : w_hit_q), in_word);
    assign w_core_data = f_fmt(r_rem ? div_remainder : div_quotient, r_word);

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = w_fast ? c_DONE : c_ISSUE;
            c_ISSUE: w_state_next = c_WAIT;
            c_WAIT:  if (div_result_valid) w_state_next = c_DONE;
            c_DONE:  if (out_ready) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
        if (flush) w_state_next = c_IDLE;
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE) & ~flush & ~reset;
        div_valid = (r_state == c_ISSUE) & ~flush;
        out_valid = (r_state == c_DONE);
        busy      = (r_state != c_IDLE);
        div_flush = flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= 64'd0;
            r_b        <= 64'd0;
            r_signed   <= 1'b0;
            r_rem      <= 1'b0;
            r_word     <= 1'b0;
            r_rd       <= 5'd0;
            r_out_data <= 64'd0;
        end else if (w_accept) begin
            r_a      <= w_a;
            r_b      <= w_b;
            r_signed <= w_signed;
            r_rem    <= in_op[1];
            r_word   <= in_word;
            r_rd     <= in_rd;
            if (w_fast) r_out_data <= w_fast_data;
        end else if (w_capture) begin
            r_out_data <= w_core_data;
        end
    end

    assign div_a      = r_a;
    assign div_b      = r_b;
    assign div_signed = r_signed;
    assign out_data   = r_out_data;
    assign out_rd     = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// ============================================================================
//  Module   : tb_div_issue_ctrl
//  Purpose  : Self-checking bench for div_issue_ctrl with a divider core model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_word, out_ready;
    logic [1:0]  in_op;
    logic [63:0] in_src1, in_src2;
    logic [4:0]  in_rd;
    logic        in_ready, div_valid, div_signed, div_flush, out_valid, busy;
    logic [63:0] div_a, div_b, out_data;
    logic [4:0]  out_rd;
    logic        div_result_valid = 1'b0;
    logic [63:0] div_quotient = 64'd0, div_remainder = 64'd0;

    int          n_checks = 0, n_fail = 0, n_launch = 0;
    int          core_cnt = -1, core_delay = 3;
    logic [63:0] core_q, core_r, last_data;
    logic        cv = 1'b0, cs, cw;
    logic [63:0] ca, cb;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
        .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
        .div_valid(div_valid), .div_a(div_a), .div_b(div_b), .div_signed(div_signed),
        .div_flush(div_flush), .div_result_valid(div_result_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .busy(busy)
    );

    // Divider core: answers each launch after core_delay extra cycles.
    always @(negedge clk) begin
        div_result_valid = 1'b0;
        if (core_cnt == 0) begin
            div_result_valid = 1'b1;
            div_quotient     = core_q;
            div_remainder    = core_r;
            core_cnt         = -1;
        end else if (core_cnt > 0) begin
            core_cnt--;
        end
        if (div_valid) begin
            n_launch++;
            if (div_b == 64'd0 || (div_signed && div_b == '1)) begin
                core_q = 64'd0 - div_a;
                core_r = 64'd0;
            end else if (div_signed) begin
                core_q = 64'($signed(div_a) / $signed(div_b));
                core_r = 64'($signed(div_a) % $signed(div_b));
            end else begin
                core_q = div_a / div_b;
                core_r = div_a % div_b;
            end
            core_cnt = core_delay;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics evaluated arithmetically.
    task automatic model(input logic [1:0] op, input logic w, input logic [63:0] s1, s2,
                         output logic [63:0] a, b, res, output logic special);
        logic        sg;
        logic [63:0] q, r;
        sg = (op == 2'd0 || op == 2'd2);
        a  = w ? (sg ? 64'($signed(s1[31:0])) : {32'd0, s1[31:0]}) : s1;
        b  = w ? (sg ? 64'($signed(s2[31:0])) : {32'd0, s2[31:0]}) : s2;
        special = (b == 0) || (sg && b == '1 && (a == 64'h8000_0000_0000_0000 ||
                                                 (w && a == 64'hFFFF_FFFF_8000_0000)));
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sg && b == '1 && a == 64'h8000_0000_0000_0000) begin
            q = a;
            r = 0;
        end else if (sg) begin
            q = 64'($signed(a) / $signed(b));
            r = 64'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        res = (op >= 2'd2) ? r : q;
        if (w) res = 64'($signed(res[31:0]));
    endtask

    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] s1, s2,
                          input int stall);
        logic [63:0] ea, eb, er;
        logic        fast, sg;
        logic [4:0]  rd;
        int          cyc, l0;
        model(op, w, s1, s2, ea, eb, er, fast);
        sg = (op == 2'd0 || op == 2'd2);
`ifdef DIV_RESULT_CACHE_EN
        if (!fast && cv && ca == ea && cb == eb && cs == sg && cw == w) fast = 1'b1;
`endif
        rd = 5'($urandom_range(0, 31));
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_word = w; in_src1 = s1; in_src2 = s2; in_rd = rd;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        l0 = n_launch;
        @(negedge clk);
        in_valid = 1'b0; in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
        cyc = 1;
        check("div_a", div_a, ea);
        check("div_b", div_b, eb);
        check("div_signed", 64'(div_signed), 64'(sg));
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid", 64'(out_valid), 64'd1);
        check("latency", 64'(cyc), fast ? 64'd1 : 64'(3 + core_delay));
        check("launches", 64'(n_launch - l0), fast ? 64'd0 : 64'd1);
        check("in_ready_busy", 64'(in_ready), 64'd0);
        repeat (stall) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, er);
            check("hold_rd", 64'(out_rd), 64'(rd));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        check("out_data", out_data, er);
        check("out_rd", 64'(out_rd), 64'(rd));
        last_data = out_data;
        if (!fast) begin
            cv = 1'b1; ca = ea; cb = eb; cs = sg; cw = w;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clear", 64'(out_valid), 64'd0);
        check("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'd7;
            3: return '1;
            4: return 64'h8000_0000_0000_0000;
            5: return 64'h0000_0000_8000_0000;
            6: return 64'h0000_0000_FFFF_FFFF;
            7: return 64'h0000_0001_FFFF_FFFF;
            8: return 64'($urandom_range(0, 1000));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_word = 1'b0;
        in_src1 = 64'd0; in_src2 = 64'd0; in_rd = 5'd0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_div_valid", 64'(div_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_div_a", div_a, 64'd0);
        check("rst_div_b", div_b, 64'd0);
        check("rst_div_signed", 64'(div_signed), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_op(2'd0, 1'b0, 64'd100, 64'd7, 5);           check("plan_div", last_data, 64'd14);
        run_op(2'd2, 1'b0, 64'd100, 64'd7, 0);           check("plan_rem", last_data, 64'd2);
        run_op(2'd1, 1'b0, 64'h1234, 64'd0, 0);          check("plan_divu0", last_data, '1);
        run_op(2'd3, 1'b0, 64'h1234, 64'd0, 0);          check("plan_remu0", last_data, 64'h1234);
        run_op(2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        check("plan_ovf_div", last_data, 64'h8000_0000_0000_0000);
        run_op(2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        check("plan_ovf_rem", last_data, 64'd0);
        run_op(2'd0, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd3, 1);
        check("plan_divw", last_data, 64'hFFFF_FFFF_FFFF_FFFB);
        run_op(2'd2, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd3, 0);
        check("plan_remw", last_data, '1);
        run_op(2'd1, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'd1, 0);
        check("plan_divuw", last_data, '1);

        // Kill an op while the core is working; its late completion must be dropped.
        core_delay = 6;
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'd1; in_word = 1'b0; in_src1 = 64'd999; in_src2 = 64'd10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("flush_busy", 64'(busy), 64'd1);
        flush = 1'b1; in_valid = 1'b1;
        #1;
        check("flush_div_flush", 64'(div_flush), 64'd1);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_no_out", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | out_valid | busy;
        end
        check("stale_ignored", 64'(seen), 64'd0);
        core_delay = 2;
        run_op(2'd1, 1'b0, 64'd999, 64'd10, 0);          check("post_flush", last_data, 64'd99);

        for (int i = 0; i < 40; i++) begin
            core_delay = $urandom_range(0, 5);
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
                   $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Issue/retire controller in front of the backend's iterative 64-bit divider core. It accepts a decoded RV64M divide/remainder micro-op from execute and prepares the operands, including the 32-bit W-variant extension. It resolves divide-by-zero and signed overflow locally, launches and waits on the core, and selects quotient or remainder. It then returns the RISC-V-correct 64-bit result to writeback over a valid/ready handshake.

## Interface
- No parameters; datapath fixed at 64 bits, rd tag at 5 bits.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  pipeline kill; highest priority
- in_valid  in  1  op offered
- in_ready  out  1  op accepted when in_valid & in_ready
- in_op  in  2  0 DIV, 1 DIVU, 2 REM, 3 REMU
- in_word  in  1  W variant (DIVW/DIVUW/REMW/REMUW)
- in_src1 / in_src2  in  64  dividend / divisor
- in_rd  in  5  destination tag, returned unchanged
- div_valid  out  1  one-cycle launch pulse to core
- div_a / div_b  out  64  prepared operands, registered
- div_signed  out  1  signed divide select
- div_flush  out  1  kill to core
- div_result_valid  in  1  core completion pulse
- div_quotient / div_remainder  in  64  core results, sign-correct when div_signed=1
- out_valid  out  1  result valid
- out_ready  in  1  writeback accepts
- out_data  out  64  final result
- out_rd  out  5  tag of result
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready = 1 & !flush.
  - On handshake, latch in_rd, op, word, and the prepared operands.
  - Operand preparation: word & signed → sign-extend src[31:0]; word & unsigned → zero-extend src[31:0]; else pass through.
  - Signed means in_op ∈ {0,2}.
- Special cases are evaluated on the prepared operands at handshake:
  - Divisor == 0: quotient = all ones; remainder = prepared dividend.
  - Signed overflow: dividend = most-negative (64-bit, or −2^31 for W) and divisor = −1. Quotient = dividend; remainder = 0.
  - Either case → IDLE → DONE with the result loaded directly. The core is never launched.
- Otherwise IDLE → ISSUE.
- ISSUE: div_valid = 1 for exactly this cycle → WAIT.
- WAIT: hold div_a, div_b and div_signed stable. On div_result_valid, capture the selected value (quotient for ops 0/1, remainder for 2/3) → DONE.
- DONE: out_valid = 1; out_data and out_rd stable. Leave to IDLE on out_ready.
- W result: out_data = sign-extend of selected[31:0], for all four W ops including unsigned.
- Flush, any state: next state IDLE, out_valid = 0 next cycle, pending op discarded.
  - div_flush = flush combinationally.
  - A handshake is never accepted in the flush cycle.
- div_result_valid outside WAIT is ignored.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_rd 0, div_valid 0, busy 0, div_a/div_b 0, div_signed 0. in_ready is 1 from the first cycle after reset deasserts.
- Handshake at cycle T:
  - Special case: out_valid at T+1.
  - Normal: div_valid at T+1; out_valid the cycle after div_result_valid is seen.
- Throughput: one op in flight. in_ready = 0 from T+1 until the cycle after the out handshake.
- out_valid holds until out_ready, with data unchanged (no retraction except by flush or reset).
- Reset mid-operation behaves like flush, and all reset values apply.

## Configuration
- DIV_RESULT_CACHE_EN defined:
  - Hold a register of the last core-completed {prepared a, prepared b, signed, word, quotient, remainder, valid}.
  - A new non-special op matching a, b, signed and word goes IDLE → DONE using the cached value (latency 1, no div_valid). This covers the DIV-then-REM idiom.
  - The valid bit is cleared only by reset. Flushed ops never update the cache.
- Undefined: no cache storage; every non-special op launches the core.

## Test plan
- DIV 100/7, then REM 100/7 (cache off) → out_data 14, then 2; div_valid pulses once per op; div_signed=1.
- DIVU src1=0x1234, src2=0 → out_valid at T+1, out_data 0xFFFF_FFFF_FFFF_FFFF, no div_valid. REMU same operands → 0x1234.
- DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000 at T+1. REM → 0.
- W ops:
  - DIVW src1=0x0000_0000_FFFF_FFF0, src2=3 → div_a=0xFFFF_FFFF_FFFF_FFF0, out 0xFFFF_FFFF_FFFF_FFFB.
  - REMW same operands → 0xFFFF_FFFF_FFFF_FFFF.
  - DIVUW src1=0x1_FFFF_FFFF, src2=1 → div_a=0xFFFF_FFFF, out 0xFFFF_FFFF_FFFF_FFFF.
- Flush during WAIT → div_flush high the same cycle, state IDLE next cycle, no out_valid; a later div_result_valid is ignored; the next op completes correctly.
- out_ready held low 5 cycles in DONE → out_valid/out_data/out_rd stable, in_ready 0. With DIV_RESULT_CACHE_EN, DIV 100/7 then REM 100/7 → second result 2 at T+1, no div_valid.
